// File: rtl/henc_stream_pkg.sv
// Shared constants, state type and code-layout helpers for the SECDED(39,32) stream encoder.
// Layout: bit 0 is overall parity, Hamming parity at power-of-two positions, data elsewhere.
package henc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CODE_W = 39;
  localparam int unsigned N_PAR  = 6;

  localparam int unsigned OVR_POS = 0;
  localparam int unsigned P1_POS  = 1;
  localparam int unsigned P2_POS  = 2;
  localparam int unsigned P4_POS  = 4;
  localparam int unsigned P8_POS  = 8;
  localparam int unsigned P16_POS = 16;
  localparam int unsigned P32_POS = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic is_par_pos(input int p);
    return (p == P1_POS) || (p == P2_POS) || (p == P4_POS) ||
           (p == P8_POS) || (p == P16_POS) || (p == P32_POS);
  endfunction

  // Data bit index carried at codeword position p (data fills non-parity slots in order).
  function automatic int data_idx(input int p);
    int n;
    n = 0;
    for (int q = 1; q < p; q++) begin
      if (!is_par_pos(q)) n++;
    end
    return n;
  endfunction

  function automatic logic [CODE_W-1:0] cover_mask(input int k);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int p = 1; p < int'(CODE_W); p++) begin
      if (((p >> k) & 1) != 0) m = m | (CODE_W'(1) << p);
    end
    return m;
  endfunction

endpackage

// File: rtl/henc_stream_if.sv
// Input/output stream bundle of the SECDED encoder: upstream word + injection, downstream codeword.
interface henc_stream_if;
  import henc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] d_in;
  logic              inj_en;
  logic [CODE_W-1:0] inj_mask;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] d_out;

  modport master (
    output in_valid, d_in, inj_en, inj_mask, out_ready,
    input  in_ready, out_valid, d_out
  );

  modport slave (
    input  in_valid, d_in, inj_en, inj_mask, out_ready,
    output in_ready, out_valid, d_out
  );

endinterface

// File: rtl/henc_stream_core.sv
// Combinational SECDED(39,32) encoder: Hamming parity over data positions, then overall parity.
module henc_core
  import henc_pkg::*;
(
  input  logic [DATA_W-1:0] d_in,
  output logic [CODE_W-1:0] codeword
);

  logic [CODE_W-1:0] data_map;
  logic [N_PAR-1:0]  par;
  logic [CODE_W-1:1] code_hi;

  assign data_map[OVR_POS] = 1'b0;

  for (genvar p = 1; p < CODE_W; p++) begin : g_pos
    if (is_par_pos(p)) begin : g_par
      localparam int unsigned K = $clog2(p);
      assign data_map[p] = 1'b0;
      assign code_hi[p]  = par[K];
    end else begin : g_dat
      localparam int unsigned DI = data_idx(p);
      assign data_map[p] = d_in[DI];
      assign code_hi[p]  = d_in[DI];
    end
  end

  for (genvar k = 0; k < N_PAR; k++) begin : g_chk
    assign par[k] = ^(data_map & cover_mask(k));
  end

  assign codeword = {code_hi, ^code_hi};

endmodule

// File: rtl/henc_stream.sv
// SECDED stream encoder with a 2-entry output/skid buffer, optional error injection
// and an accepted-word counter.
module henc_stream
  import henc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  henc_stream_if.slave     bus,
  output logic [CNT_W-1:0] word_cnt
);

  state_t            state, state_nxt;
  logic              in_ready_r;
  logic [CODE_W-1:0] out_reg, skid_reg;
  logic [CODE_W-1:0] enc_word, new_word;
  logic              in_xfer, out_xfer;
  logic              load_out, load_skid, pop_skid;

  henc_core u_core (
    .d_in     (bus.d_in),
    .codeword (enc_word)
  );

  assign new_word = enc_word ^ (bus.inj_en ? bus.inj_mask : '0);
  assign in_xfer  = bus.in_valid && in_ready_r;
  assign out_xfer = (state != EMPTY) && bus.out_ready;

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = ONE;
          load_out  = 1'b1;
        end
      end
      ONE: begin
        // Simultaneous in/out: the new word goes straight into the output register.
        if (in_xfer && out_xfer) begin
          load_out = 1'b1;
        end else if (in_xfer) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_nxt = ONE;
          pop_skid  = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_r <= 1'b1;
      out_reg    <= '0;
      skid_reg   <= '0;
      word_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_r <= (state_nxt != TWO);
      if (load_out) begin
        out_reg <= new_word;
      end else if (pop_skid) begin
        out_reg <= skid_reg;
      end
      if (load_skid) skid_reg <= new_word;
      if (in_xfer)   word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = (state != EMPTY);
  assign bus.d_out     = out_reg;

endmodule

// File: tb/tb_henc_stream.sv
// Self-checking bench for henc_stream: directed golden/backpressure/reset cases plus
// randomized traffic against a queue-based reference with a positional Hamming model.
module tb_henc_stream;
  import henc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  henc_stream_if bus();
  henc_stream_if bus4();

  logic [15:0] word_cnt;
  logic [3:0]  word_cnt4;

  henc_stream #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .word_cnt (word_cnt)
  );

  henc_stream #(.CNT_W(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus4),
    .word_cnt (word_cnt4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CODE_W-1:0] exp_q[$];
  logic [DATA_W-1:0] dat_q[$];
  logic [15:0]       exp_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference Hamming code: position p (1..38) holds data unless p is a power of two;
  // parity at 2^b covers every position with bit b set; bit 0 makes total parity even.
  function automatic logic [CODE_W-1:0] ref_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    int k;
    logic x;
    cw = '0;
    k = 0;
    for (int p = 1; p < int'(CODE_W); p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[6'(p)] = d[5'(k)];
        k++;
      end
    end
    for (int b = 0; b < 6; b++) begin
      x = 1'b0;
      for (int p = 1; p < int'(CODE_W); p++) begin
        if (((p >> b) & 1) == 1) x = x ^ cw[6'(p)];
      end
      cw[6'(1 << b)] = x;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] ref_decode(input logic [CODE_W-1:0] cw_in);
    logic [CODE_W-1:0] cw;
    logic [DATA_W-1:0] d;
    int syn;
    int k;
    cw = cw_in;
    syn = 0;
    for (int p = 1; p < int'(CODE_W); p++) begin
      if (cw[6'(p)]) syn = syn ^ p;
    end
    if (syn != 0 && syn < int'(CODE_W)) cw[6'(syn)] = ~cw[6'(syn)];
    d = '0;
    k = 0;
    for (int p = 1; p < int'(CODE_W); p++) begin
      if ((p & (p - 1)) != 0) begin
        d[5'(k)] = cw[6'(p)];
        k++;
      end
    end
    return d;
  endfunction

  // One clock: compare outputs against the model, drive inputs, advance the model.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic ie,
                       input logic [CODE_W-1:0] m, input logic ordy, output logic acc);
    logic rdy;
    rdy = (exp_q.size() < 2);
    check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
    check("in_ready", 64'(bus.in_ready), 64'(rdy));
    check("word_cnt", 64'(word_cnt), 64'(exp_cnt));
    if (exp_q.size() > 0) check("d_out", 64'(bus.d_out), 64'(exp_q[0]));
    bus.in_valid  = v;
    bus.d_in      = d;
    bus.inj_en    = ie;
    bus.inj_mask  = m;
    bus.out_ready = ordy;
    if (ordy && exp_q.size() > 0) begin
      check("roundtrip", 64'(ref_decode(bus.d_out)), 64'(dat_q[0]));
      void'(exp_q.pop_front());
      void'(dat_q.pop_front());
    end
    acc = v && rdy;
    if (acc) begin
      exp_q.push_back(ref_encode(d) ^ (ie ? m : '0));
      dat_q.push_back(d);
      exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.inj_en    = 1'b0;
    bus4.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    dat_q.delete();
    exp_cnt = '0;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_word_cnt", 64'(word_cnt), 64'(0));
    check("rst_d_out", 64'(bus.d_out), 64'(0));
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);
    check("drained", 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    logic acc;
    logic [DATA_W-1:0] w2;
    bus.in_valid   = 1'b0;
    bus.d_in       = '0;
    bus.inj_en     = 1'b0;
    bus.inj_mask   = '0;
    bus.out_ready  = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.d_in      = '0;
    bus4.inj_en    = 1'b0;
    bus4.inj_mask  = '0;
    bus4.out_ready = 1'b1;
    exp_cnt        = '0;

    do_reset();

    // Golden word, one-cycle latency.
    cycle(1'b1, 32'hcafe_baca, 1'b0, '0, 1'b1, acc);
    check("gold_d_out", 64'(bus.d_out), 64'(39'h65_bfae_58b5));
    check("gold_valid", 64'(bus.out_valid), 64'(1));
    check("gold_cnt", 64'(word_cnt), 64'(1));
    drain();

    // All-zero word encodes to zero.
    cycle(1'b1, 32'h0, 1'b0, '0, 1'b0, acc);
    check("zero_d_out", 64'(bus.d_out), 64'(0));
    check("zero_valid", 64'(bus.out_valid), 64'(1));
    drain();

    // Single-bit injection is corrected back by the decoder.
    cycle(1'b1, 32'hcafe_baca, 1'b1, 39'h00_0000_2000, 1'b1, acc);
    check("inj_d_out", 64'(bus.d_out), 64'(39'h65_bfae_78b5));
    check("inj_decode", 64'(ref_decode(bus.d_out)), 64'(32'hcafe_baca));
    drain();

    // Backpressure: two accepted, third held until space opens.
    cycle(1'b1, $urandom, 1'b0, '0, 1'b0, acc);
    cycle(1'b1, $urandom, 1'b0, '0, 1'b0, acc);
    check("bp_in_ready", 64'(bus.in_ready), 64'(0));
    w2 = $urandom;
    cycle(1'b1, w2, 1'b0, '0, 1'b0, acc);
    check("bp_full_valid", 64'(bus.out_valid), 64'(1));
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) cycle(1'b1, w2, 1'b0, '0, 1'b1, acc);
    check("bp_third_taken", 64'(acc), 64'(1));
    bus.in_valid = 1'b0;
    drain();

    // Reset while two words are buffered discards both.
    cycle(1'b1, $urandom, 1'b0, '0, 1'b0, acc);
    cycle(1'b1, $urandom, 1'b0, '0, 1'b0, acc);
    check("mid_full", 64'(bus.in_ready), 64'(0));
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, acc);

    // Full-rate streaming.
    for (int i = 0; i < 100; i++) cycle(1'b1, $urandom, 1'b0, '0, 1'b1, acc);
    drain();

    // Random traffic with sporadic single-bit injection, including inj_en with no transfer.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0),
            CODE_W'(1) << $urandom_range(0, CODE_W - 1), 1'($urandom_range(0, 2) != 0), acc);
    end
    drain();

    // Counter wrap on the 4-bit instance.
    do_reset();
    bus4.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus4.d_in = $urandom;
      @(posedge clk);
      #1;
      if (i == 15) check("wrap_zero", 64'(word_cnt4), 64'(0));
    end
    bus4.in_valid = 1'b0;
    check("wrap_one", 64'(word_cnt4), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/henc_stream.md
HENC_STREAM -- requirements
Module: henc_stream

Interface
REQ-001 Parameter CNT_W, default 16, width of the accepted-word counter.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low, sampled on rising clk.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 d_in  input  32  data word to encode.
REQ-007 inj_en  input  1  apply inj_mask to the word accepted this cycle.
REQ-008 inj_mask  input  39  bit-flip mask XORed into that codeword.
REQ-009 out_valid  output  1  codeword present on d_out.
REQ-010 out_ready  input  1  downstream consumes d_out this cycle.
REQ-011 d_out  output  39  SECDED(39,32) codeword, bit layout identical to what hdec consumes.
REQ-012 word_cnt  output  CNT_W  count of accepted input words.

Function
REQ-013 Encoding SHALL be the single-error-correct/double-error-detect Hamming code decoded by hdec: 32 data bits, 6 Hamming parity bits, 1 overall parity bit.
REQ-014 Golden values: d_in 32'hcafe_baca SHALL encode to 39'h65_bfae_58b5; d_in 32'h0 SHALL encode to 39'h0.
REQ-015 Handshake rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-016 Buffering: a 2-entry buffer (output register plus skid register) SHALL hold encoded words; state machine EMPTY, ONE, TWO.
REQ-017 Transitions: EMPTY->ONE on input transfer; ONE->TWO on input transfer without output transfer; ONE->EMPTY on output transfer without input transfer; TWO->ONE on output transfer; all other cases hold state.
REQ-018 Simultaneous input and output transfer in ONE SHALL stay in ONE with the new word on d_out the next cycle.
REQ-019 in_ready SHALL be a registered signal, high exactly when state is not TWO; combinational in_valid->in_ready paths are forbidden.
REQ-020 out_valid SHALL be high exactly when state is not EMPTY; d_out SHALL hold stable while out_valid && !out_ready.
REQ-021 Latency: a word accepted in cycle N into EMPTY SHALL appear on d_out with out_valid in cycle N+1.
REQ-022 Ordering: codewords SHALL leave in acceptance order; no loss or duplication.
REQ-023 Injection: when inj_en is high during an input transfer, the stored codeword SHALL be encode(d_in) XOR inj_mask; inj_en without a transfer SHALL have no effect.
REQ-024 word_cnt SHALL increment by 1 per input transfer, wrapping from all-ones to 0.
REQ-025 When in_valid is high and state is TWO, no transfer occurs and d_in is not captured.

Reset
REQ-026 While rst_n is low at a rising clk edge: state EMPTY, out_valid 0, in_ready 1 from the next cycle, word_cnt 0, d_out 0.
REQ-027 Reset mid-operation SHALL discard all buffered words; no codeword accepted before reset appears afterwards.

Structure
REQ-028 A shared package henc_pkg SHALL hold DATA_W=32, CODE_W=39, the parity bit position constants, and the state enum type.
REQ-029 One combinational sub-module henc_core (d_in[31:0] -> codeword[38:0]) SHALL implement REQ-013; henc_stream instantiates it once at the input.

Verification
REQ-030 Single word: reset, in_valid with d_in 32'hcafe_baca, out_ready 1 -> d_out 39'h65_bfae_58b5 with out_valid one cycle later, word_cnt 1.
REQ-031 Injection: d_in 32'hcafe_baca, inj_en 1, inj_mask 39'h00_0000_2000 -> d_out 39'h65_bfae_78b5; hdec on that value returns 32'hcafe_baca.
REQ-032 Backpressure: out_ready 0, three consecutive valid words -> first two accepted, in_ready low after second, third held; release out_ready -> all three emerge in order.
REQ-033 Streaming: in_valid and out_ready high for 100 cycles with random data -> one codeword per cycle, each hdec-decoded back to its input.
REQ-034 Reset mid-flight: state TWO, assert rst_n low one cycle -> out_valid 0, word_cnt 0, no stale codeword afterwards.
REQ-035 Counter wrap: CNT_W 4, 17 transfers -> word_cnt 1.
